// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; define MIPS_MULDIV_FAST_MUL_EN for single-cycle multiply
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int CW = $clog2(WIDTH);
`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   x;
  logic               is_div, neg_q, neg_r;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum, sh;
  logic [WIDTH-1:0]   dd, rem, quo, rem_f, quo_f;
  logic               ge;
  logic [2*WIDTH-1:0] step, p, p_f, res;
  assign busy = state != IDLE;
  // operand sign extraction: signed ops work on magnitudes, signs fixed up at the end
  always_comb begin
    sa    = ~op[0] & a[WIDTH-1];
    sb    = ~op[0] & b[WIDTH-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
  end
  // one shift-add (multiply) or restoring-subtract (divide) step on {upper, lower}
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? x : '0};
    sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge   = sh >= {1'b0, x};
    dd   = sh[WIDTH-1:0] - x;
    step = is_div ? {ge ? dd : sh[WIDTH-1:0], acc[WIDTH-2:0], ge} : {msum, acc[WIDTH-1:1]};
  end
`ifdef MIPS_MULDIV_FAST_MUL_EN
  assign p = is_div ? acc : x * acc[WIDTH-1:0];
`else
  assign p = acc;
`endif
  // sign fix-up; a zero divisor leaves quotient all ones and remainder equal to the dividend
  always_comb begin
    rem   = acc[2*WIDTH-1:WIDTH];
    quo   = acc[WIDTH-1:0];
    rem_f = neg_r ? -rem : rem;
    quo_f = (neg_q && x != '0) ? -quo : quo;
    p_f   = neg_q ? -p : p;
    res   = is_div ? {rem_f, quo_f} : p_f;
  end
  // control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      x      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            cnt    <= '0;
            x      <= op[1] ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            state  <= (FAST && !op[1]) ? FIX : CALC;
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        default: begin
          {hi, lo} <= res;
          done     <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: table, random and corner-sequence checks of mips_muldiv against an arithmetic model
module tb_mips_muldiv;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o);
`ifdef MIPS_MULDIV_FAST_MUL_EN
    return o[1] ? 34 : 2;
`else
    return 34;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sp;
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin
        sp = longint'(sx) * longint'(sy);
        return sp;
      end
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done && n < 100);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=no_done required=done");
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    int n;
    issue(o, x, y);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({nm, "_lat"}, 64'(n + 1), 64'(lat_of(o)));
    chk({nm, "_res"}, {hi, lo}, exp);
  endtask

  initial begin
    vec_t vt[$];
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit saw_done;
    vt.push_back('{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vt.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vt.push_back('{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vt.push_back('{2'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF});
    vt.push_back('{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vt.push_back('{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003});
    vt.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
    vt.push_back('{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000});
    vt.push_back('{2'd3, 32'd100, 32'd7, 32'd2, 32'd14});
    vt.push_back('{2'd2, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF});
    vt.push_back('{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {28'd0, busy, done, 34'd0} | {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo});

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 300);
        2: rb = -($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    issue(2'd3, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 start = 1'b0; hi_we = 1'b0;
    wait_done(n);
    chk("busy_ignore_lat", 64'(n + 5), 64'd34);
    chk("busy_ignore_res", {hi, lo}, {32'd2, 32'd14});
    chk("done_cycle_busy", 64'(busy), 64'd0);
    run_op("b2b", 2'd1, 32'd3, 32'd4, 64'd12);
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("hold", {hi, lo}, 64'd12);

    issue(2'd2, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_state", {busy, 63'd0} | {hi, lo}, 64'd0);
    #3 reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);

    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 lo_we = 1'b0;
    chk("mtlo", {hi, lo}, {32'd0, 32'h1234});

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA;
    op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 hi_we = 1'b0; start = 1'b0;
    chk("mthi_with_start", {hi, lo}, {32'hAAAA, 32'h1234});
    wait_done(n);
    chk("mthi_overwrite", {hi, lo}, 64'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
